// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter
//   Shares one combinational XW x YW multiplier core between two requesters.
//   A round-robin arbiter issues at most one operand pair per cycle into a
//   registered operand stage (stage A) that drives the core. On the next edge
//   the core product is captured, bit-exact, into the result FIFO of the
//   requester that issued it. Each FIFO returns results over a valid/ready
//   channel.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (ready = grant)
//   req_x/req_y          packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_z                packed results, requester i at [i*ZW +: ZW]
//   mul_x/mul_y          registered operands to the multiplier core
//   mul_z                core product, combinational from mul_x/mul_y
//   busy                 stage A occupied or any result FIFO non-empty

module approx_mul_arbiter #(
  parameter int XW    = 8,
  parameter int YW    = 8,
  parameter int ZW    = XW + YW,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*XW-1:0] req_x,
  input  logic [2*YW-1:0] req_y,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [2*ZW-1:0] rsp_z,
  output logic [XW-1:0]   mul_x,
  output logic [YW-1:0]   mul_y,
  input  logic [ZW-1:0]   mul_z,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    elig_s;
  logic [1:0]    grant_s;
  logic [1:0]    pop_s;
  logic [1:0]    push_s;
  logic          ptr_q, ptr_d;          // 0 favours requester 0
  logic          a_valid_q, a_valid_d;
  logic          a_tag_q, a_tag_d;
  logic [XW-1:0] mul_x_q, mul_x_d;
  logic [YW-1:0] mul_y_q, mul_y_d;
  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] credit_d [2];

  // Eligibility and round-robin grant from registered credits and pointer.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig_s[i] = req_valid[i] && (credit_q[i] < CW'(DEPTH));
    end
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = ptr_q ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  assign req_ready = grant_s;
  assign pop_s     = rsp_valid & rsp_ready;
  assign push_s[0] = a_valid_q && !a_tag_q;
  assign push_s[1] = a_valid_q && a_tag_q;

  // Next state for issue stage, pointer and credits.
  always_comb begin
    ptr_d     = ptr_q;
    a_valid_d = 1'b0;
    a_tag_d   = a_tag_q;
    mul_x_d   = mul_x_q;
    mul_y_d   = mul_y_q;
    if (grant_s[0]) begin
      a_valid_d = 1'b1;
      a_tag_d   = 1'b0;
      mul_x_d   = req_x[0 +: XW];
      mul_y_d   = req_y[0 +: YW];
      ptr_d     = 1'b1;
    end else if (grant_s[1]) begin
      a_valid_d = 1'b1;
      a_tag_d   = 1'b1;
      mul_x_d   = req_x[XW +: XW];
      mul_y_d   = req_y[YW +: YW];
      ptr_d     = 1'b0;
    end else begin
      a_valid_d = 1'b0;
    end
    // Credit covers stage A plus FIFO occupancy, so the A-to-FIFO move is neutral.
    for (int i = 0; i < 2; i++) begin
      credit_d[i] = credit_q[i] + CW'(grant_s[i]) - CW'(pop_s[i]);
    end
  end

  // Issue stage, pointer and credit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 1'b0;
      a_valid_q   <= 1'b0;
      a_tag_q     <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      credit_q[0] <= '0;
      credit_q[1] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      a_valid_q   <= a_valid_d;
      a_tag_q     <= a_tag_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      credit_q[0] <= credit_d[0];
      credit_q[1] <= credit_d[1];
    end
  end

  assign mul_x = mul_x_q;
  assign mul_y = mul_y_q;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [ZW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic [ZW-1:0] last_q;   // last popped head, shown while empty

    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        last_q <= '0;
      end else begin
        if (push_s[g]) begin
          mem_q[wr_q] <= mul_z;
          wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
        end
        if (pop_s[g]) begin
          last_q <= mem_q[rd_q];
          rd_q   <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
        cnt_q <= cnt_q + CW'(push_s[g]) - CW'(pop_s[g]);
      end
    end

    assign rsp_valid[g]          = (cnt_q != '0);
    assign rsp_z[g*ZW +: ZW]     = rsp_valid[g] ? mem_q[rd_q] : last_q;

    approx_mul_arbiter_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[g]),
      .cnt   (cnt_q)
    );
  end

  assign busy = a_valid_q | (|rsp_valid);

endmodule

// Flags a push into a result FIFO that is already full.
module approx_mul_arbiter_chk #(
  parameter int CW    = 2,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] cnt
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt == CW'(DEPTH))));
endmodule

// File: tb/tb_approx_mul_arbiter.sv
module tb_approx_mul_arbiter;
  localparam int XW = 8, YW = 8, ZW = 16, DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*XW-1:0] req_x;
  logic [2*YW-1:0] req_y;
  logic [2*ZW-1:0] rsp_z;
  logic [XW-1:0]   mul_x;
  logic [YW-1:0]   mul_y;
  logic [ZW-1:0]   mul_z;
  logic            busy;

  always #5 clk = ~clk;

  // Exact bench core.
  assign mul_z = mul_x * mul_y;

  approx_mul_arbiter #(.XW(XW), .YW(YW), .ZW(ZW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queues of pending results per requester plus one
  // in-flight slot; credits are recomputed from their definition.
  int   q0[$];
  int   q1[$];
  bit   m_sv;
  int   m_st, m_sz, m_sx, m_sy;
  bit   m_fav;
  int   last_z [2];
  logic [1:0] m_grant;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    m_sv = 1'b0; m_st = 0; m_sz = 0; m_sx = 0; m_sy = 0; m_fav = 1'b0;
    last_z[0] = 0; last_z[1] = 0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic [1:0] v, input logic [15:0] x, input logic [15:0] y,
                      input logic [1:0] rr);
    int c0, c1, z0, z1;
    bit e0, e1;
    req_valid = v; req_x = x; req_y = y; rsp_ready = rr;
    #1;
    c0 = ((m_sv && m_st == 0) ? 1 : 0) + q0.size();
    c1 = ((m_sv && m_st == 1) ? 1 : 0) + q1.size();
    e0 = v[0] && (c0 < DEPTH);
    e1 = v[1] && (c1 < DEPTH);
    if (e0 && e1) m_grant = m_fav ? 2'b10 : 2'b01;
    else          m_grant = {e1, e0};
    z0 = (q0.size() > 0) ? q0[0] : last_z[0];
    z1 = (q1.size() > 0) ? q1[0] : last_z[1];
    check_eq("req_ready", {30'd0, req_ready}, {30'd0, m_grant});
    check_eq("rsp_valid", {30'd0, rsp_valid}, {30'd0, q1.size() > 0, q0.size() > 0});
    check_eq("rsp_z", rsp_z, {z1[15:0], z0[15:0]});
    check_eq("mul_xy", {16'd0, mul_x, mul_y}, {16'd0, m_sx[7:0], m_sy[7:0]});
    check_eq("busy", {31'd0, busy}, {31'd0, m_sv || q0.size() > 0 || q1.size() > 0});
    @(posedge clk);
    if (q0.size() > 0 && rr[0]) last_z[0] = q0.pop_front();
    if (q1.size() > 0 && rr[1]) last_z[1] = q1.pop_front();
    if (m_sv) begin
      if (m_st == 0) q0.push_back(m_sz);
      else           q1.push_back(m_sz);
    end
    if (m_grant != 2'b00) begin
      m_sv  = 1'b1;
      m_st  = m_grant[1] ? 1 : 0;
      m_sx  = m_grant[1] ? int'(x[15:8]) : int'(x[7:0]);
      m_sy  = m_grant[1] ? int'(y[15:8]) : int'(y[7:0]);
      m_sz  = m_sx * m_sy;
      m_fav = (m_st == 0);
    end else begin
      m_sv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; req_x = '0; req_y = '0; rsp_ready = 2'b00;
    model_clear();
    @(negedge clk); @(negedge clk);
    check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_z", rsp_z, 32'd0);
    check_eq("rst_mul", {16'd0, mul_x, mul_y}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
  endtask

  int xs [3] = '{255, 0, 1};
  int ys [3] = '{255, 173, 255};
  int ps [3] = '{65025, 0, 255};
  int bx [3] = '{2, 4, 6};
  int by [3] = '{3, 5, 7};

  initial begin
    int k, n, cyc;
    logic [15:0] rx, ry;
    logic [1:0]  rv, rr;
    model_clear();
    do_reset();

    // Single op 200*100 on requester 0.
    step(2'b01, 16'd200, 16'd100, 2'b00);
    check_eq("single_grant", {30'd0, m_grant}, 32'd1);
    step(2'b00, 16'd0, 16'd0, 2'b00);
    check_eq("single_valid", {31'd0, rsp_valid[0]}, 32'd1);
    check_eq("single_z", {16'd0, rsp_z[15:0]}, 32'd20000);
    step(2'b00, 16'd0, 16'd0, 2'b01);

    // Extremes.
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 16'(xs[i]), 16'(ys[i]), 2'b00);
      step(2'b00, 16'd0, 16'd0, 2'b00);
      check_eq("extreme_z", {16'd0, rsp_z[15:0]}, 32'(ps[i]));
      step(2'b00, 16'd0, 16'd0, 2'b01);
    end

    // Contention after reset: grants alternate starting with r0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, {8'd3, 8'd10}, {8'd7, 8'd10}, 2'b11);
      check_eq("rr_alternate", {30'd0, m_grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    for (int i = 0; i < 3; i++) step(2'b00, 16'd0, 16'd0, 2'b11);

    // Backpressure on requester 0 while requester 1 keeps streaming.
    k = 0;
    for (cyc = 0; cyc < 14; cyc++) begin
      rv = {1'b1, k < 3};
      rx = {8'($urandom_range(255)), 8'(bx[k % 3])};
      ry = {8'($urandom_range(255)), 8'(by[k % 3])};
      step(rv, rx, ry, {1'b1, cyc >= 7});
      if (m_grant[0]) k++;
      if (cyc == 6) check_eq("bp_accepted", k, 2);
    end
    check_eq("bp_all_accepted", k, 3);
    for (int i = 0; i < 4; i++) step(2'b00, 16'd0, 16'd0, 2'b11);

    // Requester 1 streaming alone with rsp_ready[1]=1.
    n = 0;
    for (cyc = 0; cyc < 20 && n < 5; cyc++) begin
      step(2'b10, {8'(n + 11), 8'd0}, {8'(n + 3), 8'd0}, 2'b10);
      if (m_grant[1]) n++;
    end
    check_eq("stream_count", n, 5);
    for (int i = 0; i < 3; i++) step(2'b00, 16'd0, 16'd0, 2'b10);

    // Reset one cycle after a 9x9 handshake.
    step(2'b01, 16'd9, 16'd9, 2'b01);
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b11;
    #1;
    check_eq("midrst_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_mul_x", {24'd0, mul_x}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 16'd0, 16'd0, 2'b11);
      check_eq("midrst_no_stale", {30'd0, rsp_valid}, 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rv = 2'($urandom_range(3));
      rr = ($urandom_range(3) == 0) ? 2'b00 : 2'($urandom_range(3));
      step(rv, 16'($urandom), 16'($urandom), rr);
    end
    for (int i = 0; i < 4; i++) step(2'b00, 16'd0, 16'd0, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
